program_loader: RTL and testbench

- Upstream of the 8-bit CPU core. Receives a program image as a byte stream over a valid/ready handshake and writes it into the 256x8 instruction memory.
- Checks an 8-bit additive checksum.
- Releases the CPU (cpu_run) only after a clean load.
- Holds the CPU halted during loading and after any failed load.

---
 rtl/program_loader.sv | 141 ++++++++++++++
 tb/tb_program_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: streams a length-prefixed image into instruction memory,
// verifies an additive checksum and releases the CPU on a clean load.
module program_loader #(
   parameter logic [7:0]  ADDR_BASE = 8'h00,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       imem_w_en,
   output logic [7:0] imem_addr,
   output logic [7:0] imem_w_data,
   output logic       cpu_run,
   output logic       busy,
   output logic       load_ok,
   output logic       load_err,
   output logic [7:0] byte_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_LOAD,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam bit         TMO_ON   = (TIMEOUT != 0);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] sum;
   logic [7:0] ptr;
   logic [7:0] tmo_cnt;
   logic [8:0] remaining;
   logic       accept;
   logic       restart;
   logic       tmo_hit;

   assign accept  = in_valid && in_ready;
   assign restart = start && !busy;
   assign tmo_hit = TMO_ON && !accept && (tmo_cnt == TMO_LAST);

   // State register; reset always wins over start.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and state-decoded status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      in_ready  = 1'b0;
      cpu_run   = 1'b0;
      load_ok   = 1'b0;
      load_err  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN;
         end
         S_LEN: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (accept)       state_nxt = S_LOAD;
            else if (tmo_hit) state_nxt = S_ERROR;
         end
         S_LOAD: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (accept && remaining == 9'd1)
               state_nxt = S_CHECK;
            else if (tmo_hit)
               state_nxt = S_ERROR;
         end
         S_CHECK: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (accept)
               state_nxt = (in_data == sum) ? S_DONE : S_ERROR;
            else if (tmo_hit)
               state_nxt = S_ERROR;
         end
         S_DONE: begin
            cpu_run = 1'b1;
            load_ok = 1'b1;
            if (start) state_nxt = S_LEN;
         end
         S_ERROR: begin
            load_err = 1'b1;
            if (start) state_nxt = S_LEN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: length capture, memory write, checksum and idle timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_w_en   <= 1'b0;
         imem_addr   <= ADDR_BASE;
         imem_w_data <= 8'h00;
         byte_count  <= 8'h00;
         ptr         <= ADDR_BASE;
         sum         <= 8'h00;
         remaining   <= 9'd0;
         tmo_cnt     <= 8'h00;
      end else begin
         imem_w_en <= 1'b0;
         if (restart) begin
            sum        <= 8'h00;
            byte_count <= 8'h00;
            tmo_cnt    <= 8'h00;
            ptr        <= ADDR_BASE;
         end
         if (busy) begin
            if (accept) tmo_cnt <= 8'h00;
            else        tmo_cnt <= tmo_cnt + 8'd1;
         end
         if (state == S_LEN && accept) begin
            if (in_data == 8'h00) remaining <= 9'd256;
            else                  remaining <= {1'b0, in_data};
         end
         if (state == S_LOAD && accept) begin
            imem_w_en   <= 1'b1;
            imem_addr   <= ptr;
            imem_w_data <= in_data;
            ptr         <= ptr + 8'd1;
            sum         <= sum + in_data;
            byte_count  <= byte_count + 8'd1;
            remaining   <= remaining - 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: per-cycle vector table plus
// directed multi-cycle sequences (wrap, gaps, timeout, reset).
module tb_program_loader;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;

   logic       d_ready, d_w_en, d_run, d_busy, d_ok, d_err;
   logic [7:0] d_addr, d_wdata, d_cnt;
   logic       w_ready, w_w_en, w_run, w_busy, w_ok, w_err;
   logic [7:0] w_addr, w_wdata, w_cnt;
   logic       t_ready, t_w_en, t_run, t_busy, t_ok, t_err;
   logic [7:0] t_addr, t_wdata, t_cnt;

   int tests;
   int failed;

   program_loader u_dut (
      .clk(clk), .reset(reset), .start(start),
      .in_data(in_data), .in_valid(in_valid),
      .in_ready(d_ready), .imem_w_en(d_w_en),
      .imem_addr(d_addr), .imem_w_data(d_wdata),
      .cpu_run(d_run), .busy(d_busy), .load_ok(d_ok),
      .load_err(d_err), .byte_count(d_cnt)
   );

   program_loader #(.ADDR_BASE(8'hFE)) u_wrap (
      .clk(clk), .reset(reset), .start(start),
      .in_data(in_data), .in_valid(in_valid),
      .in_ready(w_ready), .imem_w_en(w_w_en),
      .imem_addr(w_addr), .imem_w_data(w_wdata),
      .cpu_run(w_run), .busy(w_busy), .load_ok(w_ok),
      .load_err(w_err), .byte_count(w_cnt)
   );

   program_loader #(.TIMEOUT(4)) u_tmo (
      .clk(clk), .reset(reset), .start(start),
      .in_data(in_data), .in_valid(in_valid),
      .in_ready(t_ready), .imem_w_en(t_w_en),
      .imem_addr(t_addr), .imem_w_data(t_wdata),
      .cpu_run(t_run), .busy(t_busy), .load_ok(t_ok),
      .load_err(t_err), .byte_count(t_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r, s, v;
      logic [7:0] d;
      logic       rdy, we;
      logic [7:0] a, w;
      logic       run, bsy, ok, err;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[24];

   logic        mon_en;
   logic [15:0] wr_log[$];

   always @(negedge clk)
      if (mon_en && d_w_en) wr_log.push_back({d_addr, d_wdata});

   function automatic vec_t mk(
      input logic r, s, v, input logic [7:0] d,
      input logic rdy, we, input logic [7:0] a, w,
      input logic run, bsy, ok, err, input logic [7:0] cnt);
      vec_t x;
      x.r = r; x.s = s; x.v = v; x.d = d;
      x.rdy = rdy; x.we = we; x.a = a; x.w = w;
      x.run = run; x.bsy = bsy; x.ok = ok; x.err = err;
      x.cnt = cnt;
      return x;
   endfunction

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic step(input logic r, s, v, input logic [7:0] d);
      reset    = r;
      start    = s;
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [29:0] d_outs();
      return {d_ready, d_w_en, d_addr, d_wdata,
              d_run, d_busy, d_ok, d_err, d_cnt};
   endfunction

   logic [29:0] exp_v;
   logic [7:0]  gseq[7];
   int          bad;
   int          idx;
   int          wes;
   logic        rdy_pre;

   initial begin
      tests    = 0;
      failed   = 0;
      mon_en   = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      vecs[0]  = mk(1,0,0,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00);
      vecs[1]  = mk(0,1,0,8'h00, 1,0,8'h00,8'h00, 0,1,0,0,8'h00);
      vecs[2]  = mk(0,0,1,8'h03, 1,0,8'h00,8'h00, 0,1,0,0,8'h00);
      vecs[3]  = mk(0,0,1,8'h10, 1,1,8'h00,8'h10, 0,1,0,0,8'h01);
      vecs[4]  = mk(0,0,1,8'h20, 1,1,8'h01,8'h20, 0,1,0,0,8'h02);
      vecs[5]  = mk(0,0,1,8'h30, 1,1,8'h02,8'h30, 0,1,0,0,8'h03);
      vecs[6]  = mk(0,0,1,8'h60, 0,0,8'h02,8'h30, 1,0,1,0,8'h03);
      vecs[7]  = mk(0,0,0,8'h00, 0,0,8'h02,8'h30, 1,0,1,0,8'h03);
      vecs[8]  = mk(0,1,0,8'h00, 1,0,8'h02,8'h30, 0,1,0,0,8'h00);
      vecs[9]  = mk(0,0,1,8'h02, 1,0,8'h02,8'h30, 0,1,0,0,8'h00);
      vecs[10] = mk(0,0,1,8'hAA, 1,1,8'h00,8'hAA, 0,1,0,0,8'h01);
      vecs[11] = mk(0,0,1,8'h55, 1,1,8'h01,8'h55, 0,1,0,0,8'h02);
      vecs[12] = mk(0,0,1,8'h00, 0,0,8'h01,8'h55, 0,0,0,1,8'h02);
      vecs[13] = mk(0,0,0,8'h00, 0,0,8'h01,8'h55, 0,0,0,1,8'h02);
      vecs[14] = mk(0,1,0,8'h00, 1,0,8'h01,8'h55, 0,1,0,0,8'h00);
      vecs[15] = mk(0,0,1,8'h01, 1,0,8'h01,8'h55, 0,1,0,0,8'h00);
      vecs[16] = mk(0,0,1,8'h07, 1,1,8'h00,8'h07, 0,1,0,0,8'h01);
      vecs[17] = mk(0,0,1,8'h07, 0,0,8'h00,8'h07, 1,0,1,0,8'h01);
      vecs[18] = mk(1,1,0,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00);
      vecs[19] = mk(0,1,0,8'h00, 1,0,8'h00,8'h00, 0,1,0,0,8'h00);
      vecs[20] = mk(0,1,1,8'h02, 1,0,8'h00,8'h00, 0,1,0,0,8'h00);
      vecs[21] = mk(0,1,1,8'h11, 1,1,8'h00,8'h11, 0,1,0,0,8'h01);
      vecs[22] = mk(0,0,1,8'h22, 1,1,8'h01,8'h22, 0,1,0,0,8'h02);
      vecs[23] = mk(0,0,1,8'h33, 0,0,8'h01,8'h22, 1,0,1,0,8'h02);

      for (int i = 0; i < 24; i++) begin
         step(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].d);
         exp_v = {vecs[i].rdy, vecs[i].we, vecs[i].a, vecs[i].w,
                  vecs[i].run, vecs[i].bsy, vecs[i].ok,
                  vecs[i].err, vecs[i].cnt};
         check($sformatf("vec%0d", i), 32'(d_outs()), 32'(exp_v));
      end

      // 256-byte load wrapping the address from FE
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'h00);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         step(0, 0, 1, 8'(i));
         if (!w_w_en || w_addr !== 8'(8'hFE + i) ||
             w_wdata !== 8'(i))
            bad++;
         if (i == 0)   check("wrap_first", 32'(w_addr), 32'hFE);
         if (i == 2)   check("wrap_third", 32'(w_addr), 32'h00);
         if (i == 255) check("wrap_last",  32'(w_addr), 32'hFD);
      end
      check("wrap_stream", 32'(bad), 32'd0);
      step(0, 0, 1, 8'h80);
      check("wrap_ok", 32'({w_ok, w_run, w_err}), 32'b110);
      check("wrap_cnt", 32'(w_cnt), 32'h00);

      // 5-byte load with random gaps in in_valid
      gseq[0] = 8'h05; gseq[1] = 8'h01; gseq[2] = 8'h02;
      gseq[3] = 8'h03; gseq[4] = 8'h04; gseq[5] = 8'h05;
      gseq[6] = 8'h0F;
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      wr_log.delete();
      mon_en = 1'b1;
      idx = 0;
      bad = 0;
      for (int c = 0; c < 400 && idx < 7; c++) begin
         reset    = 1'b0;
         start    = 1'b0;
         in_valid = 1'($urandom_range(0, 1));
         in_data  = gseq[idx];
         rdy_pre  = d_ready;
         @(posedge clk);
         #1;
         if (in_valid && rdy_pre) idx++;
         if (idx < 7 && !d_busy) bad++;
      end
      step(0, 0, 0, 8'h00);
      mon_en = 1'b0;
      check("gap_accepts", 32'(idx), 32'd7);
      check("gap_busy", 32'(bad), 32'd0);
      check("gap_ok", 32'({d_ok, d_busy}), 32'b10);
      check("gap_strobes", 32'(wr_log.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check($sformatf("gap_wr%0d", i),
               32'((i < wr_log.size()) ? wr_log[i] : 16'hFFFF),
               32'({8'(i), 8'(i + 1)}));

      // idle timeout with TIMEOUT=4
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'h02);
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      check("tmo_3idle", 32'({t_busy, t_err}), 32'b10);
      step(0, 0, 0, 8'h00);
      check("tmo_4idle", 32'({t_err, t_ready, t_run, t_busy}),
            32'b1000);

      // reset in the middle of a load
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'h04);
      step(0, 0, 1, 8'h01);
      step(0, 0, 1, 8'h02);
      check("rst_pre", 32'({d_w_en, d_addr, d_wdata}),
            32'({1'b1, 8'h01, 8'h02}));
      step(1, 0, 1, 8'h03);
      check("rst_mid", 32'(d_outs()), 32'd0);
      wes = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 8'h00);
         if (d_w_en) wes++;
      end
      check("rst_no_wr", 32'(wes), 32'd0);
      step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'h04);
      step(0, 0, 1, 8'h01);
      step(0, 0, 1, 8'h02);
      step(0, 0, 1, 8'h03);
      step(0, 0, 1, 8'h04);
      step(0, 0, 1, 8'h0A);
      check("rst_reload", 32'({d_ok, d_run, d_err, d_cnt}),
            32'({3'b110, 8'h04}));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
